mdu_iter: RTL



---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_shift_core.sv | 60 ++++++
 rtl/mdu_iter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes, FSM states
// and opcode decode helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } op_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Even opcodes are the two's-complement variants.
    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op[2:1] == 2'b01);
    endfunction

    function automatic logic op_is_acc(input op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_sub(input op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Shared shift register and single (WIDTH+1)-bit adder: shift-add multiply and
// restoring divide, one bit per step, on magnitudes only.
module mdu_shift_core
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] ld_lo_i,
    input  logic [WIDTH-1:0] ld_m_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             add_cin;
    logic [WIDTH+1:0] sum;
    logic             fits;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    // Divide: trial-subtract the divisor from the shifted remainder.
    // Multiply: conditionally add the multiplicand, then shift the pair right.
    always_comb begin
        add_x   = div_i ? {hi_o, lo_o[WIDTH-1]} : {1'b0, hi_o};
        add_y   = div_i ? ~{1'b0, m_q} : (lo_o[0] ? {1'b0, m_q} : '0);
        add_cin = div_i;
        sum     = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(add_cin);
        fits    = sum[WIDTH+1];
        if (div_i) begin
            hi_nxt = fits ? sum[WIDTH-1:0] : add_x[WIDTH-1:0];
            lo_nxt = {lo_o[WIDTH-2:0], fits};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo_o[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_o <= '0;
            lo_o <= '0;
            m_q  <= '0;
        end else if (load_i) begin
            hi_o <= '0;
            lo_o <= ld_lo_i;
            m_q  <= ld_m_i;
        end else if (step_i) begin
            hi_o <= hi_nxt;
            lo_o <= lo_nxt;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO accumulate; fixed WIDTH+2 cycle
// latency from acceptance to result, sign handling around an unsigned core.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned DW = 2 * WIDTH;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             load;
    logic             step;
    logic [CNT_W-1:0] cnt;
    op_e              op_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;

    op_e              op_in;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] ld_lo;
    logic [WIDTH-1:0] ld_m;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;

    logic [DW-1:0]    prod;
    logic [DW-1:0]    addend;
    logic [DW-1:0]    base;
    logic [DW-1:0]    mac;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // Operand magnitudes and the core load mapping for the incoming op.
    always_comb begin
        op_in = op_e'(op_i);
        a_neg = op_is_signed(op_in) & a_i[WIDTH-1];
        b_neg = op_is_signed(op_in) & b_i[WIDTH-1];
        a_abs = a_neg ? (~a_i + WIDTH'(1)) : a_i;
        b_abs = b_neg ? (~b_i + WIDTH'(1)) : b_i;
        ld_lo = op_is_div(op_in) ? a_abs : b_abs;
        ld_m  = op_is_div(op_in) ? b_abs : a_abs;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    state_nxt = S_BUSY;
                    load      = 1'b1;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    mdu_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .step_i  (step),
        .div_i   (op_is_div(op_q)),
        .ld_lo_i (ld_lo),
        .ld_m_i  (ld_m),
        .hi_o    (core_hi),
        .lo_o    (core_lo)
    );

    // Sign fixup and HI/LO accumulate applied to the unsigned core result.
    always_comb begin
        prod   = {core_hi, core_lo};
        addend = ((neg_a_q ^ neg_b_q) ^ op_is_sub(op_q)) ? (~prod + DW'(1)) : prod;
        base   = op_is_acc(op_q) ? {acc_hi_q, acc_lo_q} : '0;
        mac    = base + addend;
        quo    = div_zero_q ? '1
               : ((neg_a_q ^ neg_b_q) ? (~core_lo + WIDTH'(1)) : core_lo);
        rem    = neg_a_q ? (~core_hi + WIDTH'(1)) : core_hi;
        res_hi = op_is_div(op_q) ? rem : mac[DW-1:WIDTH];
        res_lo = op_is_div(op_q) ? quo : mac[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            op_q       <= OP_MULT;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
        end else begin
            busy_o  <= (state_nxt != S_IDLE);
            valid_o <= 1'b0;
            if (load) begin
                op_q       <= op_in;
                neg_a_q    <= a_neg;
                neg_b_q    <= b_neg;
                div_zero_q <= (b_i == '0);
                acc_hi_q   <= hi_i;
                acc_lo_q   <= lo_i;
                cnt        <= CNT_W'(WIDTH);
            end else if (step) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == S_DONE && !flush_i) begin
                hi_o    <= res_hi;
                lo_o    <= res_lo;
                valid_o <= 1'b1;
            end
        end
    end

endmodule
